// File: rtl/census_window_ctrl.sv
// Raster sequencer for the census-transform window datapath: it tracks the pixel position, drives the window shift enable, and flags complete windows with backpressure.
// Optional build macro CENSUS_CTRL_BORDER_EN: emits a window on every pixel and adds win_border to mark incomplete ones.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no pixel of the current frame accepted yet
// S_FILL   | rows above WIN_H-1 still filling, no window can be complete
// S_STREAM | windows produced whenever the column span is complete
// S_DONE   | single cycle after the last pixel of the frame, frame_done=1
module census_window_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int WIN_W      = 5,
    parameter int WIN_H      = 5,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic             out_ready,
    output logic             shift_en,
    output logic             win_valid,
    output logic [CNT_W-1:0] col,
    output logic [CNT_W-1:0] row,
    output logic             frame_done
`ifdef CENSUS_CTRL_BORDER_EN
    ,
    output logic             win_border
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(IMG_WIDTH - 1);
    localparam logic [CNT_W-1:0] ROW_LAST    = CNT_W'(IMG_HEIGHT - 1);
    localparam logic [CNT_W-1:0] WIN_COL_MIN = CNT_W'(WIN_W - 1);
    localparam logic [CNT_W-1:0] WIN_ROW_MIN = CNT_W'(WIN_H - 1);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             win_valid_q, win_valid_d;
    logic             win_border_q, win_border_d;

    logic             accept;
    logic             new_frame;
    logic [CNT_W-1:0] pos_c;
    logic [CNT_W-1:0] pos_r;
    logic             win_full;
    logic             last_pix;
    logic             rows_filled;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_border_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_border_q <= win_border_d;
        end
    end

    // Position the pixel presented this cycle would occupy if accepted.
    always_comb begin
        new_frame = (state_q == S_IDLE) || (state_q == S_DONE);
        pos_c     = col_q + ONE;
        pos_r     = row_q;
        if (new_frame) begin
            pos_c = '0;
            pos_r = '0;
        end else if (col_q == COL_LAST) begin
            pos_c = '0;
            pos_r = (row_q == ROW_LAST) ? '0 : row_q + ONE;
        end
        win_full    = (pos_c >= WIN_COL_MIN) && (pos_r >= WIN_ROW_MIN);
        last_pix    = (pos_c == COL_LAST) && (pos_r == ROW_LAST);
        // The pixel after this one lands in a row that can complete a window.
        rows_filled = (pos_r >= WIN_ROW_MIN) ||
                      ((pos_c == COL_LAST) && ((pos_r + ONE) >= WIN_ROW_MIN));
    end

    always_comb begin
        pix_ready = !(win_valid_q && !out_ready);
        accept    = pix_valid && pix_ready;

        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        win_valid_d  = win_valid_q;
        win_border_d = win_border_q;

        if (accept) begin
            col_d = pos_c;
            row_d = pos_r;
            if (last_pix) begin
                state_d = S_DONE;
            end else if (rows_filled) begin
                state_d = S_STREAM;
            end else begin
                state_d = S_FILL;
            end
`ifdef CENSUS_CTRL_BORDER_EN
            win_valid_d  = 1'b1;
            win_border_d = !win_full;
`else
            win_valid_d  = win_full;
            win_border_d = 1'b0;
`endif
        end else begin
            if (state_q == S_DONE) begin
                state_d = S_IDLE;
            end
            if (out_ready) begin
                win_valid_d  = 1'b0;
                win_border_d = 1'b0;
            end
        end
    end

    assign shift_en   = accept;
    assign win_valid  = win_valid_q;
    assign col        = col_q;
    assign row        = row_q;
    assign frame_done = (state_q == S_DONE);

`ifdef CENSUS_CTRL_BORDER_EN
    assign win_border = win_border_q;
`else
    logic unused_border;
    assign unused_border = win_border_q;
`endif

endmodule
